// File: rtl/stk_mem_init_engine.sv
// Re-triggerable table initialiser: walks an inclusive, possibly wrapping,
// line range and issues one patterned write per granted cycle.
module stk_mem_init_engine #(
    parameter int N      = 256,
    parameter int W      = 128,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_last,
    input  logic [W-1:0]      i_pattern,
    input  logic              i_abort,
    input  logic              i_wgnt,
    output logic              o_wen_r,
    output logic [ADDR_W-1:0] o_waddr_r,
    output logic [W-1:0]      o_wdata_r,
    output logic              o_busy_r,
    output logic              o_done_r,
    output logic              o_aborted_r
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUSY = 3'b010,
        DONE = 3'b100
    } state_t;

    localparam logic [1:0] M_ZERO  = 2'd0;
    localparam logic [1:0] M_CONST = 2'd1;
    localparam logic [1:0] M_LINK  = 2'd2;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] last_q;
    logic [W-1:0]      pat_q;
    logic [ADDR_W-1:0] addr_d;
    logic              at_last;

    // LINK points each line at its successor; the final line gets the terminator
    function automatic logic [W-1:0] line_data(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] l,
        input logic [W-1:0]      p
    );
        logic [ADDR_W-1:0] a_inc;
        a_inc = a + 1'b1;
        unique case (m)
            M_ZERO:  line_data = '0;
            M_CONST: line_data = p;
            M_LINK:  line_data = (a == l) ? p : W'(a_inc);
            default: line_data = W'(a);
        endcase
    endfunction

    always_comb begin
        addr_d  = o_waddr_r + 1'b1;
        at_last = (o_waddr_r == last_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            last_q      <= '0;
            pat_q       <= '0;
            o_wen_r     <= 1'b0;
            o_waddr_r   <= '0;
            o_wdata_r   <= '0;
            o_busy_r    <= 1'b0;
            o_done_r    <= 1'b0;
            o_aborted_r <= 1'b0;
        end else begin
            o_done_r    <= 1'b0;
            o_aborted_r <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        state_q   <= BUSY;
                        mode_q    <= i_mode;
                        last_q    <= i_last;
                        pat_q     <= i_pattern;
                        o_wen_r   <= 1'b1;
                        o_busy_r  <= 1'b1;
                        o_waddr_r <= i_base;
                        o_wdata_r <= line_data(i_mode, i_base, i_last, i_pattern);
                    end
                end
                BUSY: begin
                    // abort wins even when the same cycle carries a grant
                    if (i_abort) begin
                        state_q     <= IDLE;
                        o_wen_r     <= 1'b0;
                        o_busy_r    <= 1'b0;
                        o_aborted_r <= 1'b1;
                    end else if (o_wen_r && i_wgnt) begin
                        if (at_last) begin
                            state_q  <= DONE;
                            o_wen_r  <= 1'b0;
                            o_done_r <= 1'b1;
                        end else begin
                            o_waddr_r <= addr_d;
                            o_wdata_r <= line_data(mode_q, addr_d, last_q, pat_q);
                        end
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    o_busy_r <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    o_wen_r  <= 1'b0;
                    o_busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stk_mem_init_engine.sv
// Scoreboard bench for stk_mem_init_engine: a range/pattern model queues the
// expected writes and pulses, a monitor pops them as the DUT presents them.
module tb_stk_mem_init_engine;

    localparam int N  = 16;
    localparam int W  = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [1:0]    i_mode = '0;
    logic [AW-1:0] i_base = '0;
    logic [AW-1:0] i_last = '0;
    logic [W-1:0]  i_pattern = '0;
    logic          i_abort = 1'b0;
    logic          i_wgnt = 1'b0;
    logic          o_wen_r;
    logic [AW-1:0] o_waddr_r;
    logic [W-1:0]  o_wdata_r;
    logic          o_busy_r;
    logic          o_done_r;
    logic          o_aborted_r;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int           kind;
        int           a;
        logic [W-1:0] d;
    } ev_t;

    ev_t sb[$];

    stk_mem_init_engine #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_mode      (i_mode),
        .i_base      (i_base),
        .i_last      (i_last),
        .i_pattern   (i_pattern),
        .i_abort     (i_abort),
        .i_wgnt      (i_wgnt),
        .o_wen_r     (o_wen_r),
        .o_waddr_r   (o_waddr_r),
        .o_wdata_r   (o_wdata_r),
        .o_busy_r    (o_busy_r),
        .o_done_r    (o_done_r),
        .o_aborted_r (o_aborted_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: count = ((last-base) mod N)+1 lines starting at base.
    // kind 0 write, 1 done pulse, 2 aborted pulse.
    task automatic expect_run(input int m, input int b, input int l,
                              input logic [W-1:0] p, input int nwr,
                              input int fin);
        ev_t e;
        int  cnt;
        int  a;
        cnt = ((l - b + N) % N) + 1;
        if (nwr < 0 || nwr > cnt) nwr = cnt;
        for (int i = 0; i < nwr; i++) begin
            a = (b + i) % N;
            e.kind = 0;
            e.a = a;
            case (m)
                0:       e.d = '0;
                1:       e.d = p;
                2:       e.d = (a == l) ? p : W'((a + 1) % N);
                default: e.d = W'(a);
            endcase
            sb.push_back(e);
        end
        if (fin != 0) begin
            e.kind = fin;
            e.a = 0;
            e.d = '0;
            sb.push_back(e);
        end
    endtask

    task automatic pop_chk(input int kind);
        ev_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: got kind %0d addr %0d, want no event",
                     kind, o_waddr_r);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind ||
            (kind == 0 && (int'(o_waddr_r) != e.a || o_wdata_r !== e.d))) begin
            n_err++;
            $display("FAIL sb_event: got kind %0d addr %0d data %0h, want kind %0d addr %0d data %0h",
                     kind, o_waddr_r, o_wdata_r, e.kind, e.a, e.d);
        end
    endtask

    task automatic mon();
        bit            hold;
        logic [AW-1:0] h_a;
        logic [W-1:0]  h_d;
        hold = 1'b0;
        h_a = '0;
        h_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold && o_wen_r) begin
                chk("hold_addr", W'(o_waddr_r), W'(h_a));
                chk("hold_data", o_wdata_r, h_d);
            end
            if (o_wen_r && i_wgnt) pop_chk(0);
            if (o_done_r) pop_chk(1);
            if (o_aborted_r) pop_chk(2);
            hold = o_wen_r && !i_wgnt;
            h_a = o_waddr_r;
            h_d = o_wdata_r;
        end
    endtask

    task automatic scramble();
        i_mode    = 2'($urandom);
        i_base    = AW'($urandom);
        i_last    = AW'($urandom);
        i_pattern = $urandom;
    endtask

    // gm: 0 grant held, 1 grant 1,0,0 repeating, 2 random grant
    task automatic run(input int m, input int b, input int l,
                       input logic [W-1:0] p, input int gm, input bit poke);
        int cnt;
        int done_cyc;
        int end_cyc;
        cnt = ((l - b + N) % N) + 1;
        expect_run(m, b, l, p, -1, 1);
        i_mode    = 2'(m);
        i_base    = AW'(b);
        i_last    = AW'(l);
        i_pattern = p;
        i_start   = 1'b1;
        i_wgnt    = 1'($urandom_range(0, 1));
        tick();
        i_start = 1'b0;
        scramble();
        chk("start_wen", W'(o_wen_r), 1);
        chk("start_addr", W'(o_waddr_r), b);
        chk("start_busy", W'(o_busy_r), 1);
        done_cyc = -1;
        end_cyc  = -1;
        for (int c = 1; c < 2000; c++) begin
            case (gm)
                0:       i_wgnt = 1'b1;
                1:       i_wgnt = (c % 3 == 1);
                default: i_wgnt = ($urandom_range(0, 3) != 0);
            endcase
            i_start = poke && (c == 2);
            tick();
            if (o_done_r) done_cyc = c + 1;
            if (!o_busy_r) begin
                end_cyc = c + 1;
                break;
            end
        end
        i_start = 1'b0;
        i_wgnt  = 1'b0;
        if (end_cyc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: busy still high after 2000 cycles, want idle");
        end else if (gm == 0) begin
            chk("done_latency", done_cyc, cnt + 1);
            chk("idle_cycle", end_cyc, cnt + 2);
        end else begin
            chk("done_before_idle", done_cyc, end_cyc - 1);
        end
    endtask

    task automatic stim();
        int m;
        int b;
        int l;
        repeat (3) tick();
        chk("rst_wen", W'(o_wen_r), 0);
        chk("rst_busy", W'(o_busy_r), 0);
        chk("rst_done", W'(o_done_r), 0);
        chk("rst_aborted", W'(o_aborted_r), 0);
        chk("rst_addr", W'(o_waddr_r), 0);
        chk("rst_data", o_wdata_r, 0);
        rst_n = 1'b1;
        tick();

        run(0, 0, 15, 32'h0, 0, 1'b0);
        run(2, 4, 7, 32'hFFFF_FFFF, 0, 1'b0);
        run(3, 14, 1, 32'h0, 0, 1'b0);
        run(1, 3, 12, 32'hA5, 1, 1'b1);

        // abort on the 3rd request, together with its grant
        expect_run(3, 2, 9, 32'h0, 3, 2);
        i_mode = 2'd3;
        i_base = 4'd2;
        i_last = 4'd9;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_wgnt = 1'b1;
        tick();
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        i_wgnt = 1'b0;
        chk("abort_pulse", W'(o_aborted_r), 1);
        chk("abort_nodone", W'(o_done_r), 0);
        chk("abort_wen", W'(o_wen_r), 0);
        chk("abort_busy", W'(o_busy_r), 0);
        tick();
        chk("abort_pulse_end", W'(o_aborted_r), 0);
        run(3, 0, 15, 32'h0, 0, 1'b0);

        // start and abort in the same idle cycle: nothing starts
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("startabort_busy", W'(o_busy_r), 0);
        chk("startabort_wen", W'(o_wen_r), 0);

        // reset in the middle of a run
        expect_run(2, 10, 3, 32'hFFFF_FFFF, 2, 0);
        i_mode = 2'd2;
        i_base = 4'd10;
        i_last = 4'd3;
        i_pattern = 32'hFFFF_FFFF;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_wgnt = 1'b1;
        tick();
        tick();
        i_wgnt = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mrst_wen", W'(o_wen_r), 0);
        chk("mrst_busy", W'(o_busy_r), 0);
        chk("mrst_done", W'(o_done_r), 0);
        chk("mrst_aborted", W'(o_aborted_r), 0);
        chk("mrst_addr", W'(o_waddr_r), 0);
        chk("mrst_data", o_wdata_r, 0);
        rst_n = 1'b1;
        tick();
        chk("mrst_done2", W'(o_done_r), 0);
        chk("mrst_aborted2", W'(o_aborted_r), 0);

        run(1, 5, 5, 32'h1234, 0, 1'b0);
        run(2, 9, 9, 32'hDEAD, 2, 1'b0);

        for (int r = 0; r < 40; r++) begin
            m = $urandom_range(0, 3);
            b = $urandom_range(0, N - 1);
            l = $urandom_range(0, N - 1);
            run(m, b, l, $urandom, (r % 4 == 0) ? 0 : 2, r[0]);
        end
        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        fork
            mon();
            stim();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
